// File: rtl/scan_index_sequencer.sv
// ============================================================================
// scan_index_sequencer: steps a 3-bit decoder index through masked slots
// Revision: 1.0
// ============================================================================
`default_nettype none

module scan_index_sequencer #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       cont,
    input  logic [7:0] mask,
    output logic [2:0] idx,
    output logic       idx_valid,
    output logic       busy,
    output logic       done
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    localparam logic [CW-1:0] C_RELOAD = CW'(DWELL - 1);

    state_t          r_state;
    logic [7:0]      r_mask;
    logic            r_cont;
    logic [CW-1:0]   r_cnt;

    logic [7:0]      w_start_slots;
    logic [7:0]      w_scan_slots;
    logic [2:0]      w_first_start;
    logic [2:0]      w_first_scan;
    logic [2:0]      w_next;
    logic            w_has_next;

    // Slot i lives at mask bit 7-i; flip so slot i is bit i for the searches.
    generate
        for (genvar g = 0; g < 8; g++) begin : g_rev
            assign w_start_slots[g] = mask[7-g];
            assign w_scan_slots[g]  = r_mask[7-g];
        end
    endgenerate

    // Descending loops leave the lowest qualifying slot as the final winner.
    always_comb begin
        w_first_start = 3'd0;
        w_first_scan  = 3'd0;
        w_next        = 3'd0;
        w_has_next    = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (w_start_slots[i]) begin
                w_first_start = 3'(i);
            end
            if (w_scan_slots[i]) begin
                w_first_scan = 3'(i);
            end
            if (w_scan_slots[i] && (3'(i) > idx)) begin
                w_next     = 3'(i);
                w_has_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_mask    <= 8'd0;
            r_cont    <= 1'b0;
            r_cnt     <= '0;
            idx       <= 3'd0;
            idx_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (mask != 8'd0) begin
                            r_mask    <= mask;
                            r_cont    <= cont;
                            r_cnt     <= C_RELOAD;
                            idx       <= w_first_start;
                            idx_valid <= 1'b1;
                            busy      <= 1'b1;
                            r_state   <= S_SCAN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (stop) begin
                        idx_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (w_has_next) begin
                        idx   <= w_next;
                        r_cnt <= C_RELOAD;
                    end else if (r_cont) begin
                        idx   <= w_first_scan;
                        r_cnt <= C_RELOAD;
                    end else begin
                        idx_valid <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_scan_index_sequencer.sv
// ============================================================================
// tb_scan_index_sequencer: directed and random checks of two dwell settings
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_scan_index_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       cont;
    logic [7:0] mask;

    logic [2:0] idx0, idx1;
    logic       v0, v1, b0, b1, d0, d1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    scan_index_sequencer #(.DWELL(4), .CW(8)) dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont), .mask(mask),
        .idx(idx0), .idx_valid(v0), .busy(b0), .done(d0)
    );

    scan_index_sequencer #(.DWELL(1), .CW(8)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .cont(cont), .mask(mask),
        .idx(idx1), .idx_valid(v1), .busy(b1), .done(d1)
    );

    // Reference: the scan is "walk the list of enabled slots, DWELL cycles each".
    int         dw[2] = '{4, 1};
    bit         m_busy[2];
    bit         m_valid[2];
    bit         m_done[2];
    bit         m_cont[2];
    logic [7:0] m_mask[2];
    int         m_idx[2];
    int         m_pos[2];
    int         m_left[2];

    function automatic int nth_slot(logic [7:0] m, int n);
        int c = 0;
        for (int i = 0; i < 8; i++) begin
            if (m[7-i]) begin
                if (c == n) return i;
                c++;
            end
        end
        return -1;
    endfunction

    function automatic int popc(logic [7:0] m);
        int c = 0;
        for (int i = 0; i < 8; i++) c += int'(m[i]);
        return c;
    endfunction

    task automatic model_step(input int k);
        if (rst) begin
            m_busy[k]  = 0;
            m_valid[k] = 0;
            m_done[k]  = 0;
            m_idx[k]   = 0;
            m_mask[k]  = 8'd0;
            m_cont[k]  = 0;
        end else begin
            m_done[k] = 0;
            if (!m_busy[k]) begin
                if (start) begin
                    if (mask == 8'd0) begin
                        m_done[k] = 1;
                    end else begin
                        m_mask[k]  = mask;
                        m_cont[k]  = cont;
                        m_busy[k]  = 1;
                        m_valid[k] = 1;
                        m_pos[k]   = 0;
                        m_idx[k]   = nth_slot(mask, 0);
                        m_left[k]  = dw[k];
                    end
                end
            end else if (stop) begin
                m_busy[k]  = 0;
                m_valid[k] = 0;
            end else begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    m_pos[k]++;
                    if (m_pos[k] == popc(m_mask[k])) begin
                        if (m_cont[k]) begin
                            m_pos[k] = 0;
                        end else begin
                            m_busy[k]  = 0;
                            m_valid[k] = 0;
                            m_done[k]  = 1;
                        end
                    end
                    if (m_busy[k]) begin
                        m_idx[k]  = nth_slot(m_mask[k], m_pos[k]);
                        m_left[k] = dw[k];
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit was_rst;
        @(posedge clk);
        was_rst = rst;
        model_step(0);
        model_step(1);
        #1;
        check("valid0", 32'(v0), 32'(m_valid[0]));
        check("busy0",  32'(b0), 32'(m_busy[0]));
        check("done0",  32'(d0), 32'(m_done[0]));
        if (m_valid[0] || m_done[0] || was_rst) check("idx0", 32'(idx0), 32'(m_idx[0]));
        check("valid1", 32'(v1), 32'(m_valid[1]));
        check("busy1",  32'(b1), 32'(m_busy[1]));
        check("done1",  32'(d1), 32'(m_done[1]));
        if (m_valid[1] || m_done[1] || was_rst) check("idx1", 32'(idx1), 32'(m_idx[1]));
    endtask

    // Start a scan and report the cycle offset of done and the count of valid cycles.
    task automatic measure(input int k, input logic [7:0] m, input bit c, input bit hold_noise,
                           output int off, output int vc);
        mask  = m;
        cont  = c;
        start = 1'b1;
        tick();
        start = hold_noise;
        if (hold_noise) mask = 8'hFF;
        off = 1;
        vc  = 0;
        while (!(k == 0 ? d0 : d1) && off < 80) begin
            if (k == 0 ? v0 : v1) vc++;
            tick();
            off++;
        end
        start = 1'b0;
    endtask

    task automatic force_idle();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
    endtask

    initial begin
        int off, vc, len;
        rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; mask = 8'd0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_idx", 32'(idx0), 32'd0);
        check("reset_valid", 32'(v0), 32'd0);
        check("reset_busy", 32'(b0), 32'd0);
        tick();

        // Full mask single pass
        measure(0, 8'hFF, 1'b0, 1'b0, off, vc);
        check("t1_done_cycle", 32'(off), 32'd33);
        check("t1_valid_cycles", 32'(vc), 32'd32);
        force_idle();

        // Two sparse slots
        measure(0, 8'b0010_0100, 1'b0, 1'b0, off, vc);
        check("t2_done_cycle", 32'(off), 32'd9);
        check("t2_valid_cycles", 32'(vc), 32'd8);
        check("t2_busy_at_done", 32'(b0), 32'd0);
        force_idle();

        // Empty mask
        mask = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_done", 32'(d0), 32'd1);
        check("t3_valid", 32'(v0), 32'd0);
        check("t3_busy", 32'(b0), 32'd0);
        tick();

        // Continuous wrap between slots 0 and 7, then stop
        mask = 8'b1000_0001; cont = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; cont = 1'b0;
        repeat (40) tick();
        check("t4_still_busy", 32'(b0), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("t4_stop_valid", 32'(v0), 32'd0);
        check("t4_stop_busy", 32'(b0), 32'd0);
        check("t4_stop_done", 32'(d0), 32'd0);
        tick();

        // Reset in the middle of a scan
        mask = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_idx", 32'(idx0), 32'd0);
        check("t5_valid", 32'(v0), 32'd0);
        check("t5_busy", 32'(b0), 32'd0);
        check("t5_done", 32'(d0), 32'd0);
        tick();
        check("t5_idle", 32'(b0), 32'd0);

        // start and mask changes while busy are ignored
        force_idle();
        measure(0, 8'b0010_0100, 1'b0, 1'b1, off, vc);
        check("t6_done_cycle", 32'(off), 32'd9);
        check("t6_valid_cycles", 32'(vc), 32'd8);
        force_idle();

        // Single-cycle dwell
        measure(1, 8'hFF, 1'b0, 1'b0, off, vc);
        check("t6_dw1_done_cycle", 32'(off), 32'd9);
        check("t6_dw1_valid_cycles", 32'(vc), 32'd8);
        force_idle();

        // start and stop together in IDLE: start wins
        mask = 8'h10; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("start_over_stop", 32'(b0), 32'd1);
        force_idle();

        // Random scans with noise on the inputs
        repeat (30) begin
            mask  = 8'($urandom);
            cont  = 1'($urandom);
            start = 1'b1;
            tick();
            start = 1'b0;
            len = $urandom_range(5, 60);
            for (int c = 0; c < len; c++) begin
                start = ($urandom_range(0, 9) == 0);
                stop  = ($urandom_range(0, 29) == 0);
                rst   = ($urandom_range(0, 99) == 0);
                mask  = 8'($urandom);
                cont  = 1'($urandom);
                tick();
            end
            start = 1'b0; rst = 1'b0;
            force_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
